// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - round-robin arbiter with a one-hot rotating priority ring
//
// Purpose:
//   Shares one resource among N requesters. The priority pointer is a
//   one-hot ring. The grant is one-hot and registered. A grantee may hold
//   the grant for at most MAX_HOLD consecutive cycles before it is rotated away.
//
// Ports:
//   clk_i       clock; all state updates on the rising edge
//   reset_i     synchronous active-high reset
//   req_i       request vector, one bit per requester
//   gnt_o       registered one-hot grant, all-zero when idle
//   gnt_valid_o registered |gnt
//   gnt_id_o    index of the granted requester, 0 when idle
//   prio_o      one-hot ring pointer: the highest-priority index for the next pick
//   hold_cnt_o  cycles the current grant has been held (1..MAX_HOLD), 0 when idle
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N),
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   gnt_o,
  output logic           gnt_valid_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic [N-1:0]   prio_o,
  output logic [HW-1:0]  hold_cnt_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   prio_q, prio_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           rotate;
  logic [N-1:0]   prio_rot;
  logic [N-1:0]   sel_prio;
  logic [IDW:0]   pick;
  logic           found;
  logic [IDW-1:0] win;

  // Circular scan starting at the set bit of p. Returns {found, index}.
  // Iterating from the farthest offset down lets the nearest hit overwrite.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] p, input logic [N-1:0] r);
    logic [IDW:0] res;
    int start;
    int j;
    res   = '0;
    start = 0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) start = i;
    end
    for (int k = N - 1; k >= 0; k--) begin
      j = (start + k) % N;
      if (r[j]) res = {1'b1, IDW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    // Release or hold expiry both move the ring one past the grantee, and the
    // re-selection in the same edge already uses the moved ring.
    rotate   = (state_q == GRANT) && (!req_i[id_q] || (hold_q == HW'(MAX_HOLD)));
    prio_rot = {gnt_q[N-2:0], gnt_q[N-1]};
    sel_prio = rotate ? prio_rot : prio_q;
    pick     = rr_pick(sel_prio, req_i);
    found    = pick[IDW];
    win      = pick[IDW-1:0];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    id_d    = id_q;
    prio_d  = prio_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
          valid_d = 1'b1;
          id_d    = win;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (rotate) begin
          prio_d = prio_rot;
          if (found) begin
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
            valid_d = 1'b1;
            id_d    = win;
            hold_d  = HW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      prio_q  <= {{(N-1){1'b0}}, 1'b1};
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_id_o    = id_q;
  assign prio_o      = prio_q;
  assign hold_cnt_o  = hold_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb/tb_ring_rr_arbiter.sv - bench for ring_rr_arbiter against an integer reference model
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] prio;
  logic [3:0] hold_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference state: owner index (-1 = idle), pointer index, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id),
    .prio_o     (prio),
    .hold_cnt_o (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input int start, input logic [3:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] r);
    int w;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      w = first_from(m_ptr, r);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end else if (!r[m_owner] || m_held == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % N;
      w = first_from(m_ptr, r);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end else begin
        m_owner = -1;
        m_held  = 0;
      end
    end else begin
      m_held++;
    end
  endtask

  task automatic compare_model();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("prio", 32'(prio), 32'(4'b0001 << m_ptr));
    check("hold_cnt", 32'(hold_cnt), 32'(m_held));
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic cyc(input logic rst, input logic [3:0] r);
    reset = rst;
    req   = r;
    @(posedge clk);
    model_edge(rst, r);
    #1;
    compare_model();
  endtask

  initial begin
    logic [3:0] r;
    logic [1:0] order [$];
    logic [3:0] last_gnt;
    logic       all_valid;
    reset = 1'b1;
    req   = 4'b0000;

    // 1. Reset with all requests pending, then first grant one edge after release.
    cyc(1'b1, 4'b1111);
    cyc(1'b1, 4'b1111);
    check("t1_gnt_reset", 32'(gnt), 32'h0);
    check("t1_prio_reset", 32'(prio), 32'h1);
    check("t1_hold_reset", 32'(hold_cnt), 32'h0);
    cyc(1'b0, 4'b1111);
    check("t1_first_gnt", 32'(gnt), 32'h1);

    // 2. Grantee drops its request after holding two cycles: handoff 0,1,2,3,0.
    cyc(1'b1, 4'b1111);
    last_gnt  = 4'b0000;
    all_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      cyc(1'b0, r);
      if (gnt !== last_gnt) order.push_back(gnt_id);
      last_gnt = gnt;
      if (gnt_valid !== 1'b1) all_valid = 1'b0;
    end
    check("t2_no_bubble", 32'(all_valid), 32'd1);
    check("t2_order_len", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check("t2_order", 32'(order[i]), 32'(i % 4));

    // 3. Two steady requesters alternate every MAX_HOLD cycles.
    cyc(1'b1, 4'b0101);
    for (int c = 1; c <= 17; c++) begin
      cyc(1'b0, 4'b0101);
      if (c == 8)  check("t3_hold_max", 32'(hold_cnt), 32'd8);
      if (c == 9)  check("t3_rot_to_2", 32'(gnt), 32'h4);
      if (c == 17) check("t3_rot_to_0", 32'(gnt), 32'h1);
    end

    // 4. Sole requester keeps the grant across forced rotations.
    cyc(1'b1, 4'b0010);
    for (int c = 1; c <= 17; c++) begin
      cyc(1'b0, 4'b0010);
      if (c == 9) begin
        check("t4_regrant", 32'(gnt), 32'h2);
        check("t4_hold_restart", 32'(hold_cnt), 32'd1);
        check("t4_prio", 32'(prio), 32'h4);
      end
    end

    // 5. Release by requester 3 wraps the ring to bit 0.
    cyc(1'b1, 4'b1000);
    cyc(1'b0, 4'b1000);
    check("t5_gnt3", 32'(gnt), 32'h8);
    cyc(1'b0, 4'b1001);
    cyc(1'b0, 4'b0001);
    check("t5_wrap_gnt", 32'(gnt), 32'h1);
    check("t5_wrap_prio", 32'(prio), 32'h1);

    // 6. Reset mid-grant clears everything; arbitration restarts at bit 0.
    cyc(1'b1, 4'b0100);
    cyc(1'b0, 4'b0100);
    cyc(1'b0, 4'b0100);
    cyc(1'b0, 4'b0100);
    check("t6_hold3", 32'(hold_cnt), 32'd3);
    cyc(1'b1, 4'b0100);
    check("t6_gnt_cleared", 32'(gnt), 32'h0);
    check("t6_prio_cleared", 32'(prio), 32'h1);
    cyc(1'b0, 4'b1111);
    check("t6_restart", 32'(gnt), 32'h1);

    // Randomized: sticky request bits so holds can reach MAX_HOLD, rare resets.
    r = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cyc(($urandom_range(0, 79) == 0), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
